// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: request/acknowledge bus between the M-stage access unit and the data RAM.
interface dmem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  modport master (output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, input bus_ack, bus_rdata);
  modport slave  (input bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: M-stage load/store lane steering, extension, alignment checks and RAM handshake with stall.
module dmem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  sizeM,
  input  logic        signedM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic [31:0] rdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] bad_addrM,
  output logic        bus_errM,
  dmem_access_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic        r_req, r_we, r_err, r_word, r_half, r_sign;
  logic [1:0]  r_off;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic        w_access, w_word, w_half, w_mis, w_launch, w_tmo;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_hword;
  assign w_access = memreadM | memwriteM;
  assign w_word   = sizeM[1];
  assign w_half   = sizeM == 2'b01;
  assign w_mis    = (w_half & addrM[0]) | (w_word & |addrM[1:0]);
  assign w_launch = w_access & ~w_mis;
  assign w_tmo    = r_cnt == CNT_W'(TIMEOUT - 1);
  assign w_wdata  = w_word ? wdataM : w_half ? {2{wdataM[15:0]}} : {4{wdataM[7:0]}};
  assign w_wstrb  = !memwriteM ? 4'b0000 : w_word ? 4'b1111 :
                    w_half ? (addrM[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addrM[1:0];
  // Extraction uses lane info latched at launch; the M-stage inputs may be stale by then.
  assign w_byte   = bus.bus_rdata[{r_off, 3'b000} +: 8];
  assign w_hword  = bus.bus_rdata[{r_off[1], 4'b0000} +: 16];
  assign w_ext    = r_word ? bus.bus_rdata :
                    r_half ? {{16{r_sign & w_hword[15]}}, w_hword} : {{24{r_sign & w_byte[7]}}, w_byte};
  always_ff @(posedge clka or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE ? (w_launch ? WAIT : IDLE) :
             r_state == WAIT ? ((bus.bus_ack | w_tmo) ? DONE : WAIT) : IDLE;
  end
  always_comb begin
    stallM    = rst & ((r_state == IDLE & w_launch) | r_state == WAIT);
    adelM     = rst & memreadM & ~memwriteM & w_mis;
    adesM     = rst & memwriteM & w_mis;
    bad_addrM = (adelM | adesM) ? addrM : 32'h0;
  end
  always_ff @(posedge clka or negedge rst)
    if (!rst) begin
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_word  <= 1'b0;
      r_half  <= 1'b0;
      r_sign  <= 1'b0;
      r_off   <= 2'b00;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
      r_rdata <= 32'h0;
    end else begin
      r_err <= 1'b0;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (w_launch) begin
          r_req   <= 1'b1;
          r_we    <= memwriteM;
          r_addr  <= {addrM[31:2], 2'b00};
          r_wstrb <= w_wstrb;
          r_wdata <= w_wdata;
          r_off   <= addrM[1:0];
          r_word  <= w_word;
          r_half  <= w_half;
          r_sign  <= signedM;
        end
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (bus.bus_ack) begin
          r_req <= 1'b0;
          if (!r_we) r_rdata <= w_ext;
        end else if (w_tmo) begin
          r_req <= 1'b0;
          r_err <= 1'b1;
          if (!r_we) r_rdata <= 32'h0;
        end
      end else begin
        r_cnt <= '0;
        r_req <= 1'b0;
      end
    end
  assign rdataM        = r_rdata;
  assign bus_errM      = r_err;
  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wstrb = r_wstrb;
  assign bus.bus_wdata = r_wdata;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed load/store, alignment, timeout and reset vectors against dmem_access_unit.
module tb_dmem_access_unit;
  logic        clka = 1'b0, rst = 1'b0;
  logic        memreadM = 1'b0, memwriteM = 1'b0, signedM = 1'b0;
  logic [1:0]  sizeM = 2'b00;
  logic [31:0] addrM = '0, wdataM = '0, rdataM, bad_addrM;
  logic        stallM, adelM, adesM, bus_errM;
  int          n_vec = 0, n_err = 0;
  dmem_access_unit_if bus ();
  dmem_access_unit #(.TIMEOUT(16)) dut (
    .clka(clka), .rst(rst), .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM),
    .signedM(signedM), .addrM(addrM), .wdataM(wdataM), .rdataM(rdataM), .stallM(stallM),
    .adelM(adelM), .adesM(adesM), .bad_addrM(bad_addrM), .bus_errM(bus_errM), .bus(bus)
  );
  always #5 clka = ~clka;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ram,
                      input int lat, input logic [3:0] e_strb, input logic [31:0] e_wdata,
                      input logic [31:0] e_rdata);
    int stalls;
    memreadM = rd; memwriteM = wr; sizeM = sz; signedM = sg; addrM = a; wdataM = wd;
    #1;
    stalls = int'(stallM);
    @(posedge clka); #1;
    chk({tag, ".req"}, {31'b0, bus.bus_req}, 32'd1);
    chk({tag, ".we"}, {31'b0, bus.bus_we}, {31'b0, wr});
    chk({tag, ".addr"}, bus.bus_addr, {a[31:2], 2'b00});
    chk({tag, ".strb"}, {28'b0, bus.bus_wstrb}, {28'b0, e_strb});
    if (wr) chk({tag, ".wdata"}, bus.bus_wdata, e_wdata);
    for (int i = 0; i < lat; i++) begin
      stalls += int'(stallM);
      @(posedge clka); #1;
    end
    stalls += int'(stallM);
    bus.bus_ack = 1'b1; bus.bus_rdata = ram;
    @(posedge clka); #1;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    chk({tag, ".stalls"}, 32'(stalls), 32'(2 + lat));
    chk({tag, ".done_stall"}, {31'b0, stallM}, 32'd0);
    chk({tag, ".done_req"}, {31'b0, bus.bus_req}, 32'd0);
    chk({tag, ".rdata"}, rdataM, e_rdata);
    chk({tag, ".err"}, {31'b0, bus_errM}, 32'd0);
    memreadM = 1'b0; memwriteM = 1'b0;
    @(posedge clka); #1;
  endtask
  task automatic mis(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic e_adel, input logic e_ades, input logic [31:0] e_rdata);
    memreadM = rd; memwriteM = wr; sizeM = sz; addrM = a; wdataM = 32'h5A5A5A5A;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h77777777;
    #1;
    chk({tag, ".adel"}, {31'b0, adelM}, {31'b0, e_adel});
    chk({tag, ".ades"}, {31'b0, adesM}, {31'b0, e_ades});
    chk({tag, ".bad"}, bad_addrM, a);
    chk({tag, ".stall"}, {31'b0, stallM}, 32'd0);
    @(posedge clka); #1;
    chk({tag, ".req"}, {31'b0, bus.bus_req}, 32'd0);
    chk({tag, ".rdata"}, rdataM, e_rdata);
    memreadM = 1'b0; memwriteM = 1'b0; bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    @(posedge clka); #1;
  endtask
  initial begin
    int cnt;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    repeat (2) @(posedge clka);
    #1;
    chk("rst.rdata", rdataM, 32'h0);
    chk("rst.stall", {31'b0, stallM}, 32'd0);
    chk("rst.req", {31'b0, bus.bus_req}, 32'd0);
    chk("rst.err", {31'b0, bus_errM}, 32'd0);
    chk("rst.strb", {28'b0, bus.bus_wstrb}, 32'd0);
    rst = 1'b1;
    @(posedge clka); #1;
    xfer("lw",     1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
    xfer("lb_s",   1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h80FFFF7F, 0, 4'b0000, 32'h0, 32'hFFFFFF80);
    xfer("lhu",    1, 0, 2'b01, 0, 32'h12, 32'h0, 32'h80FFFF7F, 0, 4'b0000, 32'h0, 32'h000080FF);
    xfer("lbu_w2", 1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h80FFFF7F, 2, 4'b0000, 32'h0, 32'h00000080);
    xfer("lh_s",   1, 0, 2'b01, 1, 32'h12, 32'h0, 32'h80FFFF7F, 1, 4'b0000, 32'h0, 32'hFFFF80FF);
    xfer("lb_s0",  1, 0, 2'b00, 1, 32'h14, 32'h0, 32'h1234567F, 0, 4'b0000, 32'h0, 32'h0000007F);
    xfer("lw_sz3", 1, 0, 2'b11, 0, 32'h14, 32'h0, 32'h0BADF00D, 0, 4'b0000, 32'h0, 32'h0BADF00D);
    xfer("sb",     0, 1, 2'b00, 0, 32'h05, 32'h123456AB, 32'hFFFFFFFF, 0, 4'b0010, 32'hABABABAB, 32'h0BADF00D);
    xfer("sh_hi",  0, 1, 2'b01, 0, 32'h06, 32'hCAFE1234, 32'hFFFFFFFF, 1, 4'b1100, 32'h12341234, 32'h0BADF00D);
    xfer("sh_lo",  0, 1, 2'b01, 0, 32'h00, 32'h0000BEEF, 32'hFFFFFFFF, 0, 4'b0011, 32'hBEEFBEEF, 32'h0BADF00D);
    xfer("sw",     0, 1, 2'b10, 0, 32'h08, 32'h01234567, 32'hFFFFFFFF, 0, 4'b1111, 32'h01234567, 32'h0BADF00D);
    xfer("rdwr",   1, 1, 2'b10, 0, 32'h0C, 32'h89ABCDEF, 32'h55555555, 0, 4'b1111, 32'h89ABCDEF, 32'h0BADF00D);
    mis("mis_lw",   1, 0, 2'b10, 32'h2, 1, 0, 32'h0BADF00D);
    mis("mis_sh",   0, 1, 2'b01, 32'h1, 0, 1, 32'h0BADF00D);
    mis("mis_lh",   1, 0, 2'b01, 32'h3, 1, 0, 32'h0BADF00D);
    mis("mis_rdwr", 1, 1, 2'b10, 32'h1, 0, 1, 32'h0BADF00D);
    memreadM = 1'b1; sizeM = 2'b10; addrM = 32'h30; signedM = 1'b0;
    #1;
    chk("tmo.stall0", {31'b0, stallM}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clka); #1;
      if (!bus.bus_req) break;
      cnt++;
    end
    chk("tmo.req_cycles", 32'(cnt), 32'd16);
    chk("tmo.err", {31'b0, bus_errM}, 32'd1);
    chk("tmo.rdata", rdataM, 32'h0);
    chk("tmo.stall", {31'b0, stallM}, 32'd0);
    memreadM = 1'b0;
    @(posedge clka); #1;
    chk("tmo.err_pulse", {31'b0, bus_errM}, 32'd0);
    xfer("lw_pre", 1, 0, 2'b10, 0, 32'h44, 32'h0, 32'hA5A5A5A5, 0, 4'b0000, 32'h0, 32'hA5A5A5A5);
    memreadM = 1'b1; sizeM = 2'b10; addrM = 32'h40;
    @(posedge clka); #1;
    repeat (2) begin @(posedge clka); #1; end
    chk("arst.pre_req", {31'b0, bus.bus_req}, 32'd1);
    chk("arst.pre_stall", {31'b0, stallM}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst.req", {31'b0, bus.bus_req}, 32'd0);
    chk("arst.stall", {31'b0, stallM}, 32'd0);
    chk("arst.rdata", rdataM, 32'h0);
    memreadM = 1'b0;
    @(posedge clka); #1;
    rst = 1'b1;
    @(posedge clka); #1;
    xfer("lw_post", 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h13572468, 0, 4'b0000, 32'h0, 32'h13572468);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
